// File: rtl/ttl_74238_pkg.sv
// Shared types and helpers for the 74238-style registered decoder.
// Pure combinational helpers; no latency, no backpressure.
package ttl_74238_pkg;

  // The three enable pins grouped so the gate can be reused by other decoders.
  typedef struct packed {
    logic enable1_bar;
    logic enable2_bar;
    logic enable3;
  } enables_t;

  function automatic logic enable_term(enables_t e);
    return !e.enable1_bar && !e.enable2_bar && e.enable3;
  endfunction

endpackage

// File: rtl/ttl_decode_onehot.sv
// Combinational one-hot decoder: onehot[k] = en & (sel == k), zero for out-of-range sel.
// Latency 0; no backpressure. Shared by the 74138/74139/74238 family.
module ttl_decode_onehot #(
  parameter int WIDTH_OUT = 8
) (
  input  logic                         en,
  input  logic [$clog2(WIDTH_OUT)-1:0] sel,
  output logic [WIDTH_OUT-1:0]         onehot
);

  localparam int WIDTH_IN = $clog2(WIDTH_OUT);

  // Addresses >= WIDTH_OUT match no comparator, so the word is all zeros.
  for (genvar k = 0; k < WIDTH_OUT; k++) begin : g_cmp
    assign onehot[k] = en & (sel == WIDTH_IN'(k));
  end

endmodule

// File: rtl/ttl_74238.sv
// Registered 3-to-8 (generic width) decoder with active-high outputs, 74238-style.
// Latency 1 cycle (Y valid from the sampling edge); no backpressure, one decode per cycle.
module ttl_74238
  import ttl_74238_pkg::*;
#(
  parameter int WIDTH_OUT  = 8,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Enable1_bar,
  input  logic                         Enable2_bar,
  input  logic                         Enable3,
  input  logic [$clog2(WIDTH_OUT)-1:0] A,
  output logic [WIDTH_OUT-1:0]         Y
);

  localparam int WIDTH_IN = $clog2(WIDTH_OUT);

  enables_t             enables;
  logic                 en;
  logic [WIDTH_IN-1:0]  addr;
  logic [WIDTH_OUT-1:0] d;

  assign enables = '{enable1_bar: Enable1_bar, enable2_bar: Enable2_bar, enable3: Enable3};
  assign en      = enable_term(enables);
  assign addr    = A;

  ttl_decode_onehot #(
    .WIDTH_OUT (WIDTH_OUT)
  ) u_decode (
    .en     (en),
    .sel    (addr),
    .onehot (d)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Y <= '0;
    end else begin
      Y <= d;
    end
  end

  // The delays only describe simulated settle time; this view settles at the edge.
  if (WIDTH_OUT < 2 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_illegal_params
  end

endmodule

// File: tb/tb_ttl_74238.sv
// Self-checking bench for ttl_74238: directed scenarios plus randomized traffic
// against a reference built from the decode rules, on 8- and 6-output instances.
module tb_ttl_74238;

  logic       clk;
  logic       rst;
  logic       e1b, e2b, e3;
  logic [2:0] a;
  logic [7:0] y8;
  logic       f1b, f2b, f3;
  logic [2:0] b;
  logic [5:0] y6;

  int passed = 0;
  int total  = 0;

  ttl_74238 #(.WIDTH_OUT(8), .DELAY_RISE(5), .DELAY_FALL(3)) dut8 (
    .Clk(clk), .Reset(rst), .Enable1_bar(e1b), .Enable2_bar(e2b), .Enable3(e3),
    .A(a), .Y(y8)
  );

  ttl_74238 #(.WIDTH_OUT(6), .DELAY_RISE(5), .DELAY_FALL(3)) dut6 (
    .Clk(clk), .Reset(rst), .Enable1_bar(f1b), .Enable2_bar(f2b), .Enable3(f3),
    .A(b), .Y(y6)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reference: a set output bit is 2**addr when enabled and in range, else nothing.
  function automatic logic [7:0] ref_dec(input bit r, input bit n1, input bit n2,
                                         input bit p3, input int addr, input int width);
    logic [7:0] w;
    w = 8'h00;
    if (!r && !n1 && !n2 && p3 && addr < width) w = 8'h01 << addr;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #6;
  endtask

  task automatic test_reset();
    rst = 1'b1; e1b = 1'b0; e2b = 1'b0; e3 = 1'b1; a = 3'd5;
    f1b = 1'b0; f2b = 1'b0; f3 = 1'b1; b = 3'd1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (y8 !== 8'h00) $display("FAIL reset8 edge%0d: got %b want %b", i, y8, 8'h00);
      else passed++;
      total++;
      if (y6 !== 6'h00) $display("FAIL reset6 edge%0d: got %b want %b", i, y6, 6'h00);
      else passed++;
    end
    rst = 1'b0;
    step();
    total++;
    if (y8 !== 8'b00100000) $display("FAIL reset_release: got %b want %b", y8, 8'b00100000);
    else passed++;
  endtask

  task automatic test_enables();
    logic [3:0] tbl [5];
    logic [7:0] exp [5];
    tbl[0] = {1'b0, 1'b0, 1'b1, 1'b0}; exp[0] = 8'b00000001;
    tbl[1] = {1'b0, 1'b0, 1'b0, 1'b0}; exp[1] = 8'h00;
    tbl[2] = {1'b1, 1'b0, 1'b0, 1'b0}; exp[2] = 8'h00;
    tbl[3] = {1'b1, 1'b1, 1'b1, 1'b0}; exp[3] = 8'h00;
    tbl[4] = {1'b1, 1'b0, 1'b1, 1'b0}; exp[4] = 8'h00;
    a = 3'd0;
    for (int i = 0; i < 5; i++) begin
      {e1b, e2b, e3} = tbl[i][3:1];
      step();
      total++;
      if (y8 !== exp[i]) $display("FAIL enables%0d: got %b want %b", i, y8, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_flip();
    logic [7:0] exp [3];
    exp[0] = 8'b00000010; exp[1] = 8'h00; exp[2] = 8'b00000010;
    a = 3'd1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) {e1b, e2b, e3} = 3'b110;
      else        {e1b, e2b, e3} = 3'b001;
      step();
      total++;
      if (y8 !== exp[i]) $display("FAIL flip%0d: got %b want %b", i, y8, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp;
    {e1b, e2b, e3} = 3'b001;
    for (int k = 7; k >= 0; k--) begin
      a = 3'(k);
      exp = 8'h80 >> (7 - k);
      step();
      total++;
      if (y8 !== exp) $display("FAIL sweep_a%0d: got %b want %b", k, y8, exp);
      else passed++;
    end
  endtask

  task automatic test_disabled_addr();
    logic [2:0] seq [3];
    seq[0] = 3'd0; seq[1] = 3'd5; seq[2] = 3'd2;
    {e1b, e2b, e3} = 3'b110;
    for (int i = 0; i < 3; i++) begin
      a = seq[i];
      step();
      total++;
      if (y8 !== 8'h00) $display("FAIL disabled_a%0d: got %b want %b", seq[i], y8, 8'h00);
      else passed++;
    end
    {e1b, e2b, e3} = 3'b001; a = 3'd5;
    step();
    total++;
    if (y8 !== 8'b00100000) $display("FAIL enable_with_addr: got %b want %b", y8, 8'b00100000);
    else passed++;
    a = 3'd2;
    step();
    total++;
    if (y8 !== 8'b00000100) $display("FAIL addr_change: got %b want %b", y8, 8'b00000100);
    else passed++;
  endtask

  task automatic test_midcycle();
    // Now at edge+6 with A=2 enabled; disturb inputs and restore before the next edge.
    #2;
    a = 3'd7; e3 = 1'b0; e1b = 1'b1;
    #2;
    total++;
    if (y8 !== 8'b00000100) $display("FAIL midcycle_hold: got %b want %b", y8, 8'b00000100);
    else passed++;
    #3;
    a = 3'd2; e3 = 1'b1; e1b = 1'b0;
    step();
    total++;
    if (y8 !== 8'b00000100) $display("FAIL midcycle_revert: got %b want %b", y8, 8'b00000100);
    else passed++;
  endtask

  task automatic test_width6();
    logic [5:0] exp;
    {f1b, f2b, f3} = 3'b001;
    for (int k = 0; k < 8; k++) begin
      b = 3'(k);
      exp = (k < 6) ? (6'h01 << k) : 6'h00;
      step();
      total++;
      if (y6 !== exp) $display("FAIL w6_a%0d: got %b want %b", k, y6, exp);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [7:0] exp8;
    logic [7:0] exp6;
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      {e1b, e2b, e3} = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom);
      {f1b, f2b, f3} = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom);
      a = 3'($urandom);
      b = 3'($urandom);
      exp8 = ref_dec(rst, e1b, e2b, e3, int'(a), 8);
      exp6 = ref_dec(rst, f1b, f2b, f3, int'(b), 6);
      step();
      total++;
      if (y8 !== exp8) $display("FAIL rand8 #%0d: got %b want %b", i, y8, exp8);
      else passed++;
      total++;
      if (y6 !== exp6[5:0]) $display("FAIL rand6 #%0d: got %b want %b", i, y6, exp6[5:0]);
      else passed++;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_enables();
    test_flip();
    test_sweep();
    test_disabled_addr();
    test_midcycle();
    test_width6();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
